// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the two-port RAM arbiter slice.
// Used by ram_arb_rr_sel and ram_arbiter_2p.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 10;

    typedef struct packed {
        logic                  we;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
    } ram_cmd_t;

    typedef enum logic {ARB, LOCKED} arb_state_t;

endpackage

// File: rtl/ram_arb_rr_sel.sv
// Combinational 2-way round-robin pick producing a one-hot grant.
// While locked, only the lock owner can be granted.
module ram_arb_rr_sel
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_gnt,
    input  arb_state_t state,
    input  logic       lock_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (state == LOCKED) begin
            grant[lock_owner] = valid[lock_owner];
        end else if (valid == 2'b11) begin
            // Contention: favour the port that did not win last time.
            grant[~last_gnt] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter/sequencer in front of the 1024x10 single-port RAM.
// Define RAM_ARB_LOCK_EN to add rq_lock and the LOCKED state for atomic RMW.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          rq_valid,
    input  logic [1:0]          rq_we,
`ifdef RAM_ARB_LOCK_EN
    input  logic [1:0]          rq_lock,
`endif
    input  logic [2*ADDR_W-1:0] rq_addr,
    input  logic [2*DATA_W-1:0] rq_wdata,
    output logic [1:0]          rq_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    arb_state_t state, state_next;
    logic       last_gnt, last_gnt_next;
    logic       lock_owner, lock_owner_next;
    logic [1:0] grant;
    logic       win;
    logic       hs;
    ram_cmd_t   sel_cmd;

    logic       s1_valid;
    logic       s1_owner;
    logic       rsp_pend;
    logic       rsp_owner;

    ram_arb_rr_sel u_rr_sel (
        .valid      (rq_valid),
        .last_gnt   (last_gnt),
        .state      (state),
        .lock_owner (lock_owner),
        .grant      (grant)
    );

    assign win      = grant[1];
    assign hs       = |grant;
    assign rq_ready = grant & {2{~reset}};

    always_comb begin
        sel_cmd.we    = rq_we[win];
        sel_cmd.addr  = rq_addr[win*ADDR_W +: ADDR_W];
        sel_cmd.wdata = rq_wdata[win*DATA_W +: DATA_W];
    end

    // Pointer and lock bookkeeping advance only on an accepted command.
    always_comb begin
        state_next      = state;
        last_gnt_next   = last_gnt;
        lock_owner_next = lock_owner;
        if (hs) begin
            last_gnt_next = win;
`ifdef RAM_ARB_LOCK_EN
            if (rq_lock[win]) begin
                state_next      = LOCKED;
                lock_owner_next = win;
            end else begin
                state_next = ARB;
            end
`else
            state_next = ARB;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            last_gnt   <= 1'b1;
            lock_owner <= 1'b0;
        end else begin
            state      <= state_next;
            last_gnt   <= last_gnt_next;
            lock_owner <= lock_owner_next;
        end
    end

    // Stage 1 drives the RAM pins; address and data hold while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_owner  <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            s1_valid <= hs;
            ram_we   <= hs & sel_cmd.we;
            if (hs) begin
                s1_owner  <= win;
                ram_addr  <= sel_cmd.addr;
                ram_wdata <= sel_cmd.wdata;
            end
        end
    end

    // Stage 2 captures the combinational RAM read alongside the owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_pend  <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_pend  <= s1_valid;
            rsp_owner <= s1_owner;
            rsp_rdata <= (s1_valid && !ram_we) ? ram_rdata : '0;
        end
    end

    assign rsp_valid = {rsp_pend & rsp_owner, rsp_pend & ~rsp_owner};

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed, table-driven bench for ram_arbiter_2p with a behavioural RAM.
// The lock sequence runs only when RAM_ARB_LOCK_EN is defined.
module tb_ram_arbiter_2p;

    logic        clk;
    logic        reset;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_we;
`ifdef RAM_ARB_LOCK_EN
    logic [1:0]  rq_lock;
`endif
    logic [19:0] rq_addr;
    logic [19:0] rq_wdata;
    logic [1:0]  rq_ready;
    logic [1:0]  rsp_valid;
    logic [9:0]  rsp_rdata;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [9:0]  ram_wdata;
    logic [9:0]  ram_rdata;

    logic [9:0]  mem [0:1023];

    int num_tests = 0;
    int num_fail  = 0;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] we;
        logic [9:0] a0, a1, w0, w1;
        logic [1:0] ready;
        logic       ram_we;
        logic [9:0] ram_addr;
        logic [9:0] ram_wdata;
        logic [1:0] rsp_valid;
        logic [9:0] rsp_rdata;
    } vec_t;

    vec_t vecs[$];

    ram_arbiter_2p dut (
        .clk       (clk),
        .reset     (reset),
        .rq_valid  (rq_valid),
        .rq_we     (rq_we),
`ifdef RAM_ARB_LOCK_EN
        .rq_lock   (rq_lock),
`endif
        .rq_addr   (rq_addr),
        .rq_wdata  (rq_wdata),
        .rq_ready  (rq_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, synchronous write, not cleared by this reset.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    function automatic vec_t mk(
        input logic [1:0] valid, input logic [1:0] we,
        input logic [9:0] a0, input logic [9:0] a1,
        input logic [9:0] w0, input logic [9:0] w1,
        input logic [1:0] ready, input logic xwe,
        input logic [9:0] xaddr, input logic [9:0] xwdata,
        input logic [1:0] xrv, input logic [9:0] xrd);
        vec_t v;
        v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
        v.ready = ready; v.ram_we = xwe; v.ram_addr = xaddr; v.ram_wdata = xwdata;
        v.rsp_valid = xrv; v.rsp_rdata = xrd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_tests++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                                 input logic [9:0] a0, input logic [9:0] a1,
                                 input logic [9:0] w0, input logic [9:0] w1);
        rq_valid = valid;
        rq_we    = we;
        rq_addr  = {a1, a0};
        rq_wdata = {w1, w0};
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 10'h000;
        mem[1]     = 10'h0A1;
        mem[2]     = 10'h0B2;
        mem[10'h040] = 10'h1C3;

        reset = 1'b1;
`ifdef RAM_ARB_LOCK_EN
        rq_lock = 2'b00;
`endif
        applyStimulus(2'b00, 2'b00, 10'h0, 10'h0, 10'h0, 10'h0);
        #2;
        checkOutput("reset rq_ready", 32'(rq_ready), 32'h0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset rsp_rdata", 32'(rsp_rdata), 32'h0);
        checkOutput("reset ram_we", 32'(ram_we), 32'h0);
        checkOutput("reset ram_addr", 32'(ram_addr), 32'h0);
        checkOutput("reset ram_wdata", 32'(ram_wdata), 32'h0);
        nextCycle();
        reset = 1'b0;

        // Idle after reset: nothing may move for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            #1;
            checkOutput("idle ram_we", 32'(ram_we), 32'h0);
            checkOutput("idle rsp_valid", 32'(rsp_valid), 32'h0);
            checkOutput("idle rq_ready", 32'(rq_ready), 32'h0);
            nextCycle();
        end

        // Contention, back-to-back RAW at 0x3FF, basic write/read, port 1 write.
        vecs.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 10'h0, 10'h0, 2'b01, 1'b0, 10'h000, 10'h000, 2'b00, 10'h000));
        vecs.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 10'h0, 10'h0, 2'b10, 1'b0, 10'h001, 10'h000, 2'b00, 10'h000));
        vecs.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 10'h0, 10'h0, 2'b01, 1'b0, 10'h002, 10'h000, 2'b01, 10'h0A1));
        vecs.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 10'h0, 10'h0, 2'b10, 1'b0, 10'h001, 10'h000, 2'b10, 10'h0B2));
        vecs.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 10'h0, 10'h0, 2'b01, 1'b0, 10'h002, 10'h000, 2'b01, 10'h0A1));
        vecs.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 10'h0, 10'h0, 2'b10, 1'b0, 10'h001, 10'h000, 2'b10, 10'h0B2));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h0, 10'h0, 2'b00, 1'b0, 10'h002, 10'h000, 2'b01, 10'h0A1));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h0, 10'h0, 2'b00, 1'b0, 10'h002, 10'h000, 2'b10, 10'h0B2));
        vecs.push_back(mk(2'b01, 2'b01, 10'h3FF, 10'h000, 10'h155, 10'h0, 2'b01, 1'b0, 10'h002, 10'h000, 2'b00, 10'h000));
        vecs.push_back(mk(2'b01, 2'b00, 10'h3FF, 10'h000, 10'h000, 10'h0, 2'b01, 1'b1, 10'h3FF, 10'h155, 2'b00, 10'h000));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h0, 2'b00, 1'b0, 10'h3FF, 10'h000, 2'b01, 10'h000));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h0, 2'b00, 1'b0, 10'h3FF, 10'h000, 2'b01, 10'h155));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h0, 2'b00, 1'b0, 10'h3FF, 10'h000, 2'b00, 10'h000));
        vecs.push_back(mk(2'b01, 2'b01, 10'h010, 10'h000, 10'h3A5, 10'h0, 2'b01, 1'b0, 10'h3FF, 10'h000, 2'b00, 10'h000));
        vecs.push_back(mk(2'b01, 2'b00, 10'h010, 10'h000, 10'h000, 10'h0, 2'b01, 1'b1, 10'h010, 10'h3A5, 2'b00, 10'h000));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h0, 2'b00, 1'b0, 10'h010, 10'h000, 2'b01, 10'h000));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h0, 2'b00, 1'b0, 10'h010, 10'h000, 2'b01, 10'h3A5));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h0, 2'b00, 1'b0, 10'h010, 10'h000, 2'b00, 10'h000));
        vecs.push_back(mk(2'b10, 2'b10, 10'h000, 10'h055, 10'h000, 10'h2CC, 2'b10, 1'b0, 10'h010, 10'h000, 2'b00, 10'h000));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 1'b1, 10'h055, 10'h2CC, 2'b00, 10'h000));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 1'b0, 10'h055, 10'h2CC, 2'b10, 10'h000));
        vecs.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 1'b0, 10'h055, 10'h2CC, 2'b00, 10'h000));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].w0, vecs[i].w1);
            #1;
            checkOutput($sformatf("vec%0d rq_ready", i), 32'(rq_ready), 32'(vecs[i].ready));
            checkOutput($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(vecs[i].ram_we));
            checkOutput($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].ram_addr));
            checkOutput($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].ram_wdata));
            checkOutput($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rsp_valid));
            checkOutput($sformatf("vec%0d rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].rsp_rdata));
            nextCycle();
        end

        // Reset right after a write handshake must cancel the write and its ack.
        applyStimulus(2'b01, 2'b01, 10'h040, 10'h000, 10'h111, 10'h000);
        #1;
        checkOutput("rstwr rq_ready", 32'(rq_ready), 32'h1);
        nextCycle();
        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000);
        #1;
        checkOutput("rstwr ram_we", 32'(ram_we), 32'h0);
        checkOutput("rstwr rsp_valid", 32'(rsp_valid), 32'h0);
        nextCycle();
        checkOutput("rstwr ram_we hold", 32'(ram_we), 32'h0);
        checkOutput("rstwr rsp_valid hold", 32'(rsp_valid), 32'h0);
        nextCycle();
        checkOutput("rstwr mem intact", 32'(mem[10'h040]), 32'h1C3);
        reset = 1'b0;
        applyStimulus(2'b01, 2'b00, 10'h040, 10'h000, 10'h000, 10'h000);
        #1;
        checkOutput("rstrd rq_ready", 32'(rq_ready), 32'h1);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000);
        nextCycle();
        checkOutput("rstrd rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("rstrd rsp_rdata", 32'(rsp_rdata), 32'h1C3);
        nextCycle();

`ifdef RAM_ARB_LOCK_EN
        // Port 0 won last, so port 1 takes the lock; port 0 is starved until unlock.
        rq_lock = 2'b10;
        applyStimulus(2'b11, 2'b00, 10'h001, 10'h020, 10'h000, 10'h000);
        #1;
        checkOutput("lock take", 32'(rq_ready), 32'h2);
        nextCycle();
        rq_lock = 2'b00;
        applyStimulus(2'b01, 2'b00, 10'h001, 10'h020, 10'h000, 10'h000);
        #1;
        checkOutput("lock starve", 32'(rq_ready), 32'h0);
        nextCycle();
        applyStimulus(2'b11, 2'b10, 10'h001, 10'h020, 10'h000, 10'h2AB);
        #1;
        checkOutput("lock release", 32'(rq_ready), 32'h2);
        nextCycle();
        applyStimulus(2'b01, 2'b00, 10'h001, 10'h020, 10'h000, 10'h000);
        #1;
        checkOutput("lock after", 32'(rq_ready), 32'h1);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000);
        nextCycle();
        checkOutput("lock mem write", 32'(mem[10'h020]), 32'h2AB);
`endif

        $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
Two-requester round-robin arbiter and sequencer in front of the 1024x10 single-port RAM. Requesters are typically the CPU datapath (port 0) and the loader/debug path (port 1).
- Accepts read/write commands through valid/ready handshakes.
- Registers the winning command and drives the RAM port for one cycle.
- Returns a registered response (read data or write ack) to the owning requester.
- Sits between the requesters and the RAM instance; it is the only driver of the RAM address, write-enable and write-data pins.

Parameters:
ADDR_W, 10, RAM address width (1024 locations)
DATA_W, 10, RAM word width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
rq_valid  in  2  per-requester command valid
rq_we  in  2  per-requester write (1) / read (0)
rq_addr  in  2*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W]
rq_wdata  in  2*DATA_W  per-requester write data, packed the same way
rq_ready  out  2  per-requester command accepted this cycle
rsp_valid  out  2  one-cycle response pulse to the owning requester
rsp_rdata  out  DATA_W  read data; 0 for write acks
ram_we  out  1  to RAM write_enable
ram_addr  out  ADDR_W  to RAM address
ram_wdata  out  DATA_W  to RAM data_in
ram_rdata  in  DATA_W  from RAM data_out (combinational read)

Behaviour:
- Reset (async) values:
  - rq_ready=0, rsp_valid=0, rsp_rdata=0.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - Round-robin pointer last_gnt=1, so port 0 wins first.
  - FSM state=ARB.
- Reset mid-operation drops any in-flight command and response; no RAM write occurs after reset asserts. RAM contents are cleared by the RAM's own reset input, not by this block.
- Arbitration (combinational, from rq_valid and registered state only; rq_ready never depends on rsp or RAM signals):
  - Only one valid requester: it gets ready.
  - Both valid: ready goes to the port != last_gnt.
  - At most one rq_ready bit is high per cycle.
  - Neither valid: rq_ready=0.
- Handshake at cycle T (valid & ready):
  - Command latched; last_gnt updated to the winner.
  - T+1: ram_addr/ram_we/ram_wdata driven from the command registers. ram_we is high for exactly one cycle per write, and is 0 for reads and idle cycles.
  - End of T+1: ram_rdata captured for reads (0 for writes), along with the owner id.
  - T+2: rsp_valid[owner]=1 for one cycle with rsp_rdata.
- Latency: 2 cycles from handshake to response. Throughput: 1 command per cycle, sustained back-to-back.
- Read-after-write to the same address on consecutive handshakes returns the new data, because the write commits at the end of T+1 and the read samples at T+2.
- Idle cycles: ram_addr holds its last value and ram_we=0.
- Requesters must hold rq_* stable while rq_valid=1 and rq_ready=0. Dropping valid before ready is permitted; the request is then simply not served.
- FSM states:
  - ARB: normal round-robin.
  - LOCKED: optional feature only.

Optional Feature:
Macro RAM_ARB_LOCK_EN.
- Defined:
  - Extra input rq_lock[1:0].
  - A handshake with rq_lock[i]=1 moves the FSM ARB->LOCKED with owner=i. While LOCKED, only the owner can receive ready, even if the other port is valid.
  - An owner handshake with rq_lock[i]=0 returns the FSM to ARB after that command. last_gnt=owner at that point.
  - Reset forces ARB.
  - Used for atomic read-modify-write.
- Undefined: no rq_lock port, the FSM never leaves ARB, and behaviour is pure round-robin.

Decomposition:
- Package ram_arb_pkg contains:
  - localparams RAM_ADDR_W=10 and RAM_DATA_W=10.
  - typedef struct packed {logic we; logic [9:0] addr; logic [9:0] wdata;} ram_cmd_t.
  - typedef enum logic {ARB, LOCKED} arb_state_t.
- One sub-module, ram_arb_rr_sel: purely combinational 2-way round-robin pick. Inputs: valid[1:0], last_gnt, lock state. Output: one-hot grant.

Test Plan:
1. Reset then idle → all outputs 0; ram_we never toggles over 20 cycles.
2. Port 0 writes 0x3A5 to addr 0x010 at T → ram_we=1, ram_addr=0x010, ram_wdata=0x3A5 at T+1; rsp_valid[0]=1, rsp_rdata=0 at T+2. Port 0 then reads 0x010 → rsp_rdata=0x3A5 two cycles after handshake.
3. Both ports hold valid for 6 cycles (port 0 reads 0x001, port 1 reads 0x002) → grants alternate 0,1,0,1,0,1; each port gets 3 responses with correct data.
4. Back-to-back write 0x155 to 0x3FF then read 0x3FF on consecutive cycles → read response = 0x155. Also covers the address wrap boundary 0x3FF.
5. Reset asserted at the cycle after a write handshake → ram_we stays 0, no rsp_valid; subsequent read of that address returns the pre-existing value.
6. With RAM_ARB_LOCK_EN: port 1 read 0x020 with lock=1, port 0 valid continuously → port 0 ready stays 0 until port 1 writes 0x020 with lock=0; port 0 is granted the next cycle.
